// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - op codes OP_AND .. OP_MULHU
//   - FSM state encoding ST_IDLE / ST_MUL / ST_DONE
//   - helpers: signed_lt (signed compare from a subtraction), is_mul_op
package alu_pkg;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_SLT   = 3'b100;
   localparam logic [2:0] OP_NOR   = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;
   localparam logic [2:0] OP_MULHU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Signed a < b using only sign bits and the MSB of (a - b). When the signs
   // differ the difference may overflow, so the sign of a alone decides.
   function automatic logic signed_lt(input logic a_msb,
                                      input logic b_msb,
                                      input logic diff_msb);
      return (a_msb != b_msb) ? a_msb : diff_msb;
   endfunction

   function automatic logic is_mul_op(input logic [2:0] code);
      return (code == OP_MUL) || (code == OP_MULHU);
   endfunction

endpackage

// File: rtl/alu_mc_shift_add_mul.sv
// shift_add_mul: unsigned WIDTH x WIDTH shift-add multiplier, one partial
// product per clock, always exactly WIDTH steps (no early exit).
//   clk, rst_n : clock, asynchronous active-low reset (discards partial work)
//   start      : load operands (ignored while busy)
//   a, b       : multiplicand, multiplier
//   busy       : a multiplication is in progress
//   done       : one-cycle pulse during the final step
//   product    : 2*WIDTH-bit product, valid while done is high
module shift_add_mul #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   import alu_pkg::*;

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CNT_W-1:0]   count;

   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   // The final sum is exposed combinationally so the caller can register it on
   // the same edge as the last step; this keeps total latency at WIDTH edges.
   assign product = acc_next;
   assign done    = busy && (count == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CNT_W'(1);
         if (count == CNT_W'(1)) busy <= 1'b0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         count  <= CNT_W'(WIDTH);
         busy   <= 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit ALU with registered result, valid/ready handshakes and a
// multi-cycle unsigned multiplier (MUL low half, MULHU high half).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (accept when both high)
//   op, a, b            : op code and operands, latched at accept
//   out_valid/out_ready : result handshake
//   result              : registered result
//   zero                : result == 0
//   carry_out, overflow : adder carry / signed overflow, ADD and SUB only
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);
   import alu_pkg::*;

   localparam int MSB = WIDTH - 1;

   state_t           state;
   logic [2:0]       op_q;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   logic             accept;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0] mul_res;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul_op(op);

   // SUB is a + ~b + 1; the carry out then means "no borrow".
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_c   = sub_full[WIDTH];
            alu_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, signed_lt(a[MSB], b[MSB], sub_full[MSB])};
         OP_NOR: alu_res = ~(a | b);
         default: alu_res = '0;
      endcase
   end

   shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   assign mul_res = (op_q == OP_MULHU) ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_q      <= OP_AND;
         result    <= '0;
         zero      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q <= op;
                  if (is_mul_op(op)) begin
                     state <= ST_MUL;
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     carry_out <= alu_c;
                     overflow  <= alu_v;
                     state     <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  result    <= mul_res;
                  zero      <= (mul_res == '0);
                  carry_out <= 1'b0;
                  overflow  <= 1'b0;
                  state     <= ST_DONE;
               end else if (!mul_busy) begin
                  // Multiplier idle without finishing: recover rather than hang.
                  state <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         zero;
   logic         carry_out;
   logic         overflow;

   int errors = 0;
   int checks = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sval(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   // Reference: returns {overflow, carry, result[7:0]} from plain integer math.
   function automatic logic [9:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      int ux, uy, r, s, sd;
      logic c, v;
      ux = int'(x); uy = int'(y);
      r = 0; c = 1'b0; v = 1'b0;
      case (o)
         3'd0: r = ux & uy;
         3'd1: r = ux | uy;
         3'd2: begin
            r = (ux + uy) % 256;
            c = (ux + uy) > 255;
            s = sval(ux) + sval(uy);
            v = (s > 127) || (s < -128);
         end
         3'd3: begin
            r = (ux - uy + 256) % 256;
            c = (ux >= uy);
            sd = sval(ux) - sval(uy);
            v = (sd > 127) || (sd < -128);
         end
         3'd4: r = (sval(ux) < sval(uy)) ? 1 : 0;
         3'd5: r = 255 - (ux | uy);
         3'd6: r = (ux * uy) % 256;
         default: r = (ux * uy) / 256;
      endcase
      return {v, c, 8'(r)};
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
      logic [9:0] exp;
      logic [7:0] held;
      int lat;
      exp = model(o, x, y);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), (o >= 3'd6) ? 32'd8 : 32'd0);
      chk("result", 32'(result), 32'(exp[7:0]));
      chk("zero", 32'(zero), 32'(exp[7:0] == 8'd0));
      chk("carry_out", 32'(carry_out), 32'(exp[8]));
      chk("overflow", 32'(overflow), 32'(exp[9]));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_result", 32'(result), 32'(held));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("pop_valid", 32'(out_valid), 32'd0);
      chk("pop_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;

      // Directed cases
      run_op(3'd2, 8'd200, 8'd100, 0);
      run_op(3'd3, 8'd5, 8'd7, 0);
      run_op(3'd3, 8'h80, 8'h01, 0);
      run_op(3'd3, 8'd9, 8'd9, 0);
      run_op(3'd4, 8'hFD, 8'h02, 0);
      run_op(3'd4, 8'h02, 8'hFD, 0);
      run_op(3'd6, 8'd200, 8'd200, 0);
      run_op(3'd7, 8'd200, 8'd200, 0);
      run_op(3'd6, 8'd13, 8'd11, 0);
      run_op(3'd6, 8'd77, 8'd0, 0);
      run_op(3'd0, 8'hF0, 8'h3C, 0);
      run_op(3'd1, 8'hF0, 8'h0C, 0);
      run_op(3'd5, 8'hF0, 8'h0C, 0);
      run_op(3'd2, 8'd7, 8'd9, 5);
      run_op(3'd7, 8'd255, 8'd255, 3);

      // Reset in the middle of a multiplication
      @(negedge clk);
      op = 3'd6; a = 8'd200; b = 8'd200; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midmul_out_valid", 32'(out_valid), 32'd0);
      chk("midmul_result", 32'(result), 32'd0);
      chk("midmul_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      run_op(3'd6, 8'd3, 8'd5, 0);

      // Randomized operations
      for (int n = 0; n < 40; n++) begin
         run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
